// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: fetches one GRB word per LED from pixel memory,
// feeds an external shift register and generates the one-wire bit timing,
// then holds the line low for the latch interval.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line low, waiting for start
// S_FETCH | read strobe for pixel 0
// S_WAIT  | pixel 0 arrives, captured into pbuf
// S_LOAD  | pbuf presented and loaded into the shift register
// S_BIT   | one bit period per pass, prefetch during bit 23
// S_RESET | latch low time, frame_done on its last cycle
module ws2812_frame_ctrl #(
  parameter int N_LEDS  = 64,
  parameter int AW      = 6,
  parameter int T_BIT   = 31,
  parameter int T0H     = 10,
  parameter int T1H     = 20,
  parameter int RES_CYC = 1500
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  output logic [AW-1:0] pix_addr,
  output logic          pix_rd,
  input  logic [23:0]   pix_data,
  output logic [23:0]   sr_word,
  output logic          sr_load,
  output logic          sr_shift,
  input  logic          sr_bit,
  output logic          dout
);

  localparam int CMAX = (T_BIT > RES_CYC) ? T_BIT : RES_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] T0H_C    = CW'(T0H);
  localparam logic [CW-1:0] T1H_C    = CW'(T1H);
  localparam logic [CW-1:0] BIT_LAST = CW'(T_BIT - 1);
  localparam logic [CW-1:0] RES_LAST = CW'(RES_CYC - 1);
  localparam logic [AW-1:0] LAST_LED = AW'(N_LEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_BIT,
    S_RESET
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [4:0]    bit_idx, bit_idx_nx;
  logic [AW-1:0] led_idx, led_idx_nx;
  logic [23:0]   pbuf, pbuf_nx;
  logic          dout_nx;
  logic          last_led;

  assign last_led = (led_idx == LAST_LED);
  assign busy     = (state != S_IDLE);
  assign sr_word  = pbuf;

  // State, counters, pixel buffer and the registered data line.
  // dout is registered so the line is glitch-free; it trails the bit
  // counter by one cycle, which keeps every bit period exactly T_BIT long.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      led_idx <= '0;
      pbuf    <= '0;
      dout    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      led_idx <= led_idx_nx;
      pbuf    <= pbuf_nx;
      dout    <= dout_nx;
    end
  end

  // Next-state, counter updates and strobes.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    led_idx_nx = led_idx;
    pbuf_nx    = pbuf;
    dout_nx    = 1'b0;
    pix_rd     = 1'b0;
    pix_addr   = '0;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    frame_done = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end

      S_FETCH: begin
        pix_rd   = 1'b1;
        pix_addr = '0;
        state_nx = S_WAIT;
      end

      S_WAIT: begin
        pbuf_nx  = pix_data;
        state_nx = S_LOAD;
      end

      S_LOAD: begin
        sr_load    = 1'b1;
        led_idx_nx = '0;
        bit_idx_nx = '0;
        cnt_nx     = '0;
        state_nx   = S_BIT;
      end

      S_BIT: begin
        if (cnt < T0H_C)      dout_nx = 1'b1;
        else if (cnt < T1H_C) dout_nx = sr_bit;
        else                  dout_nx = 1'b0;

        // Next pixel is fetched while the last bit of this LED is on the
        // wire, so the following LED starts without a gap.
        if (bit_idx == 5'd23 && !last_led) begin
          if (cnt == '0) begin
            pix_rd   = 1'b1;
            pix_addr = led_idx + AW'(1);
          end
          if (cnt == CW'(1)) pbuf_nx = pix_data;
        end

        if (cnt == BIT_LAST) begin
          cnt_nx = '0;
          if (bit_idx != 5'd23) begin
            sr_shift   = 1'b1;
            bit_idx_nx = bit_idx + 5'd1;
          end else if (!last_led) begin
            sr_load    = 1'b1;
            led_idx_nx = led_idx + AW'(1);
            bit_idx_nx = '0;
          end else begin
            state_nx = S_RESET;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      S_RESET: begin
        if (cnt == RES_LAST) begin
          frame_done = 1'b1;
          cnt_nx     = '0;
          state_nx   = S_IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Testbench for ws2812_frame_ctrl: two instances (3-LED and 1-LED chains)
// with behavioural pixel memories and shift registers; the expected line
// waveform is built from the pixel words and the WS2812 timing rules.
module tb_ws2812_frame_ctrl;

  localparam int T_BIT   = 31;
  localparam int T0H     = 10;
  localparam int T1H     = 20;
  localparam int RES_CYC = 1500;

  logic clk, rstn;

  logic        start3, busy3, fd3, rd3, load3, shift3, bit3, dout3;
  logic [1:0]  addr3;
  logic [23:0] pdata3, word3;

  logic        start1, busy1, fd1, rd1, load1, shift1, bit1, dout1;
  logic [0:0]  addr1;
  logic [23:0] pdata1, word1;

  ws2812_frame_ctrl #(.N_LEDS(3), .AW(2), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H),
                      .RES_CYC(RES_CYC)) u_dut3 (
    .clk(clk), .rstn(rstn), .start(start3), .busy(busy3), .frame_done(fd3),
    .pix_addr(addr3), .pix_rd(rd3), .pix_data(pdata3), .sr_word(word3),
    .sr_load(load3), .sr_shift(shift3), .sr_bit(bit3), .dout(dout3));

  ws2812_frame_ctrl #(.N_LEDS(1), .AW(1), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H),
                      .RES_CYC(RES_CYC)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .busy(busy1), .frame_done(fd1),
    .pix_addr(addr1), .pix_rd(rd1), .pix_data(pdata1), .sr_word(word1),
    .sr_load(load1), .sr_shift(shift1), .sr_bit(bit1), .dout(dout1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pixel memories: data valid only in the cycle after a read strobe,
  // random garbage otherwise, so a mistimed capture corrupts the output.
  logic [23:0] mem3 [0:3];
  logic [23:0] mem1 [0:1];
  logic [23:0] q3, q1;
  logic        rd3_d, rd1_d;
  logic [31:0] garbage;
  logic [23:0] sreg3, sreg1;

  always @(posedge clk) begin
    garbage <= $urandom;
    rd3_d   <= rd3;
    rd1_d   <= rd1;
    if (rd3) q3 <= mem3[addr3];
    if (rd1) q1 <= mem1[addr1];
  end

  assign pdata3 = rd3_d ? q3 : garbage[23:0];
  assign pdata1 = rd1_d ? q1 : garbage[31:8];

  // External 24-bit shift registers, MSB out.
  always @(posedge clk) begin
    if (load3)       sreg3 <= word3;
    else if (shift3) sreg3 <= {sreg3[22:0], 1'b0};
    if (load1)       sreg1 <= word1;
    else if (shift1) sreg1 <= {sreg1[22:0], 1'b0};
  end

  assign bit3 = sreg3[23];
  assign bit1 = sreg1[23];

  // Monitor view of whichever instance is under test.
  logic sel;
  logic m_dout, m_busy, m_fd, m_rd, m_load, m_shift;
  int   m_addr;

  always_comb begin
    m_dout  = sel ? dout1  : dout3;
    m_busy  = sel ? busy1  : busy3;
    m_fd    = sel ? fd1    : fd3;
    m_rd    = sel ? rd1    : rd3;
    m_load  = sel ? load1  : load3;
    m_shift = sel ? shift1 : shift3;
    m_addr  = sel ? int'(addr1) : int'(addr3);
  end

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else     start3 = v;
  endtask

  function automatic logic exp_bit(input int g);
    logic [23:0] w;
    w = sel ? mem1[g / 24] : mem3[g / 24];
    return w[23 - (g % 24)];
  endfunction

  // Expected line level at sample j (j=1 is the cycle after start was taken).
  function automatic logic exp_dout(input int j, input int nb);
    int g, c;
    if (j < 5 || j > 4 + nb * T_BIT) return 1'b0;
    g = (j - 5) / T_BIT;
    c = (j - 5) % T_BIT;
    return (c < (exp_bit(g) ? T1H : T0H));
  endfunction

  // mode 0: single start pulse; 1: start held through frame_done;
  // 2: random re-pulses while busy plus a pulse in the frame_done cycle.
  // Returns in the first IDLE cycle with start low.
  task automatic run_frame(input int mode);
    int   nl, nb, j_fd, j_end;
    int   first_rise, n_load, n_shift, n_ovl, n_fd, fd_at, busy_bad, dout_bad;
    int   hi, lo, e_hi, base;
    logic w[$];
    int   rd_j[$], rd_a[$];
    nl = sel ? 1 : 3;
    nb = nl * 24;
    j_fd = 3 + nb * T_BIT + RES_CYC;
    j_end = j_fd + 1;
    n_load = 0; n_shift = 0; n_ovl = 0; n_fd = 0; fd_at = -1;
    busy_bad = 0; dout_bad = 0; first_rise = -1;
    set_start(1'b1);
    for (int j = 1; j <= j_end; j++) begin
      @(negedge clk);
      w.push_back(m_dout);
      if (m_busy !== (j <= j_fd)) busy_bad++;
      if (m_fd) begin n_fd++; fd_at = j; end
      if (m_rd) begin rd_j.push_back(j); rd_a.push_back(m_addr); end
      if (m_load)  n_load++;
      if (m_shift) n_shift++;
      if (m_load && m_shift) n_ovl++;
      case (mode)
        1:       set_start(j <= j_fd);
        2:       set_start((j == j_fd) || (j < j_fd && $urandom_range(0, 63) == 0));
        default: set_start(1'b0);
      endcase
    end
    set_start(1'b0);

    for (int i = 0; i < w.size(); i++) begin
      if (first_rise < 0 && w[i] === 1'b1) first_rise = i + 1;
      if (w[i] !== exp_dout(i + 1, nb)) dout_bad++;
    end
    n_checks++;
    if (first_rise != 5) begin
      n_fail++;
      $display("FAIL first_rise: got sample %0d expected 5", first_rise);
    end
    for (int g = 0; g < nb; g++) begin
      base = 4 + g * T_BIT;
      hi = 0; lo = 0;
      while (hi < T_BIT && w[base + hi] === 1'b1) hi++;
      for (int c = hi; c < T_BIT; c++) if (w[base + c] === 1'b0) lo++;
      e_hi = exp_bit(g) ? T1H : T0H;
      n_checks++;
      if (hi != e_hi || lo != T_BIT - e_hi) begin
        n_fail++;
        $display("FAIL bit_time[%0d]: high %0d low %0d expected high %0d low %0d",
                 g, hi, lo, e_hi, T_BIT - e_hi);
      end
    end
    n_checks++;
    if (dout_bad != 0) begin
      n_fail++;
      $display("FAIL dout_wave: %0d samples differ, expected 0", dout_bad);
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL busy_wave: %0d samples differ, expected 0", busy_bad);
    end
    n_checks++;
    if (n_fd != 1 || fd_at != j_fd) begin
      n_fail++;
      $display("FAIL frame_done: %0d pulses at %0d expected 1 at %0d", n_fd, fd_at, j_fd);
    end
    n_checks++;
    if (n_load != nl || n_shift != 23 * nl) begin
      n_fail++;
      $display("FAIL strobes: load %0d shift %0d expected %0d %0d",
               n_load, n_shift, nl, 23 * nl);
    end
    n_checks++;
    if (n_ovl != 0) begin
      n_fail++;
      $display("FAIL load_shift_overlap: %0d cycles expected 0", n_ovl);
    end
    n_checks++;
    if (rd_j.size() != nl) begin
      n_fail++;
      $display("FAIL pix_rd_count: got %0d expected %0d", rd_j.size(), nl);
    end else begin
      for (int l = 0; l < nl; l++) begin
        int e_j;
        e_j = (l == 0) ? 1 : 4 + ((l - 1) * 24 + 23) * T_BIT;
        n_checks++;
        if (rd_j[l] != e_j || rd_a[l] != l) begin
          n_fail++;
          $display("FAIL pix_rd[%0d]: sample %0d addr %0d expected sample %0d addr %0d",
                   l, rd_j[l], rd_a[l], e_j, l);
        end
      end
    end
  endtask

  task automatic check_stays_idle(input string name);
    int bad;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_busy !== 1'b0 || m_rd !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: busy/pix_rd high in %0d idle cycles, expected 0", name, bad);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start3 = 1'b0; start1 = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy3, fd3, rd3, load3, shift3, dout3} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl3: got %b expected 000000", {busy3, fd3, rd3, load3, shift3, dout3});
    end
    n_checks++;
    if (addr3 !== 2'd0 || word3 !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_data3: addr %0d word %h expected 0 000000", addr3, word3);
    end
    n_checks++;
    if ({busy1, fd1, rd1, load1, shift1, dout1} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl1: got %b expected 000000", {busy1, fd1, rd1, load1, shift1, dout1});
    end
    n_checks++;
    if (addr1 !== 1'd0 || word1 !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_data1: addr %0d word %h expected 0 000000", addr1, word1);
    end
    rstn = 1'b1;
    check_stays_idle("idle_after_reset");
  endtask

  task automatic test_single_led();
    sel = 1'b1;
    mem1[0] = 24'hCA6FAE;
    mem1[1] = 24'h123456;
    run_frame(0);
    check_stays_idle("single_idle_after");
  endtask

  task automatic test_three_leds();
    sel = 1'b0;
    mem3[0] = 24'hFE0981; mem3[1] = 24'h000000; mem3[2] = 24'hFFFFFF; mem3[3] = 24'h5A5A5A;
    run_frame(0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    for (int i = 0; i < 4; i++) mem3[i] = 24'($urandom);
    run_frame(0);
    for (int i = 0; i < 4; i++) mem3[i] = 24'($urandom);
    run_frame(0);
    check_stays_idle("b2b_idle_after");
  endtask

  task automatic test_start_while_busy();
    sel = 1'b0;
    for (int i = 0; i < 4; i++) mem3[i] = 24'($urandom);
    run_frame(1);
    check_stays_idle("held_start_one_frame");
    sel = 1'b1;
    mem1[0] = 24'($urandom);
    run_frame(2);
    check_stays_idle("repulse_one_frame");
  endtask

  task automatic test_abort();
    int j_abort, fd_seen, bad;
    sel = 1'b0;
    mem3[0] = 24'hF0F0F0; mem3[1] = 24'h0F0F0F; mem3[2] = 24'hAAAAAA;
    j_abort = 4 + (24 + 5) * T_BIT + 12;
    set_start(1'b1);
    for (int j = 1; j <= j_abort; j++) begin
      @(negedge clk);
      set_start(1'b0);
    end
    n_checks++;
    if (busy3 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_precond: busy %b expected 1", busy3);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy3, fd3, rd3, load3, shift3, dout3} !== 6'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b expected 000000", {busy3, fd3, rd3, load3, shift3, dout3});
    end
    fd_seen = 0; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (fd3 !== 1'b0) fd_seen++;
      if (busy3 !== 1'b0 || dout3 !== 1'b0) bad++;
    end
    n_checks++;
    if (fd_seen != 0 || bad != 0) begin
      n_fail++;
      $display("FAIL abort_hold: frame_done %0d busy/dout %0d cycles, expected 0 0", fd_seen, bad);
    end
    rstn = 1'b1;
    @(negedge clk);
    mem3[0] = 24'h00FF00; mem3[1] = 24'h813C7E; mem3[2] = 24'($urandom);
    run_frame(0);
  endtask

  initial begin
    test_reset();
    test_single_led();
    test_three_leds();
    test_back_to_back();
    test_start_while_busy();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
